// File: rtl/quad_encoder_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quad_encoder_bank                                               |
// | Purpose  : Bank of NUM_CH independent quadrature decoders. Each channel    |
// |            synchronises its raw A/B pins, debounces them and decodes Gray  |
// |            steps (x4 or x1) into a WIDTH-bit position that wraps or        |
// |            saturates, with a step strobe, direction flag and sticky error. |
// | Ports    : clk_i      system clock, all logic on posedge                    |
// |            reset_i    asynchronous active-high reset                        |
// |            a_i, b_i   raw encoder pins per channel (asynchronous)           |
// |            clear_i    per-channel synchronous clear of the position         |
// |            err_clr_i  clears every sticky error bit                         |
// |            value_o    packed positions, channel i at [i*WIDTH +: WIDTH]     |
// |            step_o     one-cycle strobe per counted step                     |
// |            dir_o      direction of the last counted step (1 = up)          |
// |            err_o      sticky illegal-transition flag                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module quad_encoder_bank #(
  parameter int NUM_CH     = 3,
  parameter int WIDTH      = 8,
  parameter int JUMP_VALUE = 1,
  parameter int DEBOUNCE   = 4,
  parameter bit X4         = 1'b1,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       a_i,
  input  logic [NUM_CH-1:0]       b_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH*WIDTH-1:0] value_o,
  output logic [NUM_CH-1:0]       step_o,
  output logic [NUM_CH-1:0]       dir_o,
  output logic [NUM_CH-1:0]       err_o
);

  localparam int             c_CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [WIDTH:0] c_JUMP  = (WIDTH+1)'(JUMP_VALUE);

  // Map a {A,B} Gray state to its position around the forward cycle
  // 00 -> 10 -> 11 -> 01, so a step is the modulo-4 position difference.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Shared priming counter: for the first three cycles after reset the
  // filtered and previous states follow the synchroniser directly, so an
  // encoder resting at a non-zero detent never produces a spurious step.
  logic [1:0] prime_q, prime_d;
  logic       w_priming;

  assign w_priming = (prime_q != 2'd3);
  assign prime_d   = w_priming ? prime_q + 2'd1 : prime_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) prime_q <= 2'd0;
    else         prime_q <= prime_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Pin pairs are kept as {A,B}.
    logic [1:0]              sync1_q, sync2_q;
    logic [1:0]              filt_q, filt_d;
    logic [1:0]              prev_q, prev_d;
    logic [1:0][c_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]        val_q, val_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    err_q, err_d;
    logic [1:0]              w_delta;
    logic                    w_fwd, w_rev, w_ill;
    logic [WIDTH:0]          w_inc, w_dec;

    // Debounce: a pin's filtered bit follows the synchronised bit only after
    // the two have disagreed for DEBOUNCE consecutive cycles.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      prev_d = w_priming ? sync2_q : filt_q;
      if (w_priming) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (sync2_q[p] == filt_q[p]) begin
            cnt_d[p] = '0;
          end else if (cnt_q[p] == c_CNT_W'(DEBOUNCE - 1)) begin
            filt_d[p] = sync2_q[p];
            cnt_d[p]  = '0;
          end else begin
            cnt_d[p] = cnt_q[p] + c_CNT_W'(1);
          end
        end
      end
    end

    // Decode: +1 position is forward, -1 is reverse, +2 means both pins were
    // accepted together and the direction is unknowable.
    assign w_delta = gray_pos(filt_q) - gray_pos(prev_q);
    assign w_ill   = !w_priming && (w_delta == 2'd2);
    assign w_fwd   = !w_priming && (w_delta == 2'd1) && (X4 || (filt_q == 2'b00));
    assign w_rev   = !w_priming && (w_delta == 2'd3) && (X4 || (filt_q == 2'b00));
    assign w_inc   = {1'b0, val_q} + c_JUMP;
    assign w_dec   = {1'b0, val_q} - c_JUMP;

    always_comb begin
      val_d  = val_q;
      step_d = 1'b0;
      dir_d  = dir_q;
      // A new illegal transition outranks a simultaneous clear request.
      err_d  = (err_q && !err_clr_i) || w_ill;
      if (clear_i[g]) begin
        val_d = '0;
      end else if (w_fwd) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
        val_d  = (SATURATE && w_inc[WIDTH]) ? '1 : w_inc[WIDTH-1:0];
      end else if (w_rev) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
        // Bit WIDTH of the difference is the borrow out of the subtraction.
        val_d  = (SATURATE && w_dec[WIDTH]) ? '0 : w_dec[WIDTH-1:0];
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        sync1_q <= 2'b00;
        sync2_q <= 2'b00;
        filt_q  <= 2'b00;
        prev_q  <= 2'b00;
        cnt_q   <= '0;
        val_q   <= '0;
        step_q  <= 1'b0;
        dir_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        sync1_q <= {a_i[g], b_i[g]};
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        prev_q  <= prev_d;
        cnt_q   <= cnt_d;
        val_q   <= val_d;
        step_q  <= step_d;
        dir_q   <= dir_d;
        err_q   <= err_d;
      end
    end

    assign value_o[g*WIDTH +: WIDTH] = val_q;
    assign step_o[g]                 = step_q;
    assign dir_o[g]                  = dir_q;
    assign err_o[g]                  = err_q;
  end

endmodule
`default_nettype wire
